// File: rtl/fb_pkg.sv
// Shared framebuffer constants and the arbiter state encoding.
package fb_pkg;

    localparam int unsigned IMG_W     = 300;
    localparam int unsigned IMG_H     = 200;
    localparam int unsigned FB_DEPTH  = IMG_W * IMG_H;
    localparam int unsigned FB_ADDR_W = 16;
    localparam int unsigned PIX_W     = 12;

    typedef logic [1:0] fb_state_t;

    localparam fb_state_t StRun   = 2'd0;
    localparam fb_state_t StDrain = 2'd1;
    localparam fb_state_t StClear = 2'd2;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Bus bundle between the display, pixel writer, clear control and the image BRAM.
interface fb_port_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 12
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_err;
    logic              clr_start;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic              clr_done;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  rd_en, rd_addr, wr_valid, wr_addr, wr_data, clr_start, clr_color, mem_dout,
        output rd_data, rd_valid, wr_ready, wr_err, clr_busy, clr_done,
               mem_en, mem_we, mem_addr, mem_din
    );

    modport master (
        output rd_en, rd_addr, wr_valid, wr_addr, wr_data, clr_start, clr_color, mem_dout,
        input  rd_data, rd_valid, wr_ready, wr_err, clr_busy, clr_done,
               mem_en, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO holding pending {addr, data} pixel writes.
module fb_wr_fifo #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [PtrW:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FullCount);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port image BRAM arbiter: display reads > clear fill > buffered pixel writes.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W     = FB_ADDR_W,
    parameter int unsigned DATA_W     = PIX_W,
    parameter int unsigned DEPTH      = FB_DEPTH,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic               clk,
    input logic               reset,
    fb_port_arbiter_if.slave  bus
);
    localparam int unsigned       EntryW   = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    fb_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic              rd_valid_q;
    logic              wr_err_q, wr_err_d;
    logic              clr_done_q, clr_done_d;

    logic              fifo_full, fifo_empty;
    logic              push_req, addr_ok, push, pop, clr_wr;
    logic [EntryW-1:0] head;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign bus.wr_ready = !fifo_full && (state_q == StRun);
    assign push_req     = bus.wr_valid && bus.wr_ready;
    assign addr_ok      = (bus.wr_addr <= LastAddr);
    assign push         = push_req && addr_ok;
    assign clr_wr       = (state_q == StClear) && !bus.rd_en;
    assign pop          = !bus.rd_en && !fifo_empty && (state_q != StClear);
    assign {head_addr, head_data} = head;

    fb_wr_fifo #(
        .WIDTH (EntryW),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({bus.wr_addr, bus.wr_data}),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        bus.mem_en   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        if (bus.rd_en) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.rd_addr;
        end else if (clr_wr) begin
            bus.mem_en   = 1'b1;
            bus.mem_we   = 1'b1;
            bus.mem_addr = cnt_q;
            bus.mem_din  = color_q;
        end else if (pop) begin
            bus.mem_en   = 1'b1;
            bus.mem_we   = 1'b1;
            bus.mem_addr = head_addr;
            bus.mem_din  = head_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        color_d    = color_q;
        clr_done_d = 1'b0;
        wr_err_d   = push_req && !addr_ok;
        case (state_q)
            StRun: begin
                if (bus.clr_start) begin
                    color_d = bus.clr_color;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // No pushes are accepted here, so empty stays empty.
                if (fifo_empty) begin
                    cnt_d   = '0;
                    state_d = StClear;
                end
            end
            StClear: begin
                if (clr_wr) begin
                    if (cnt_q == LastAddr) begin
                        cnt_d      = '0;
                        clr_done_d = 1'b1;
                        state_d    = StRun;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StRun;
            cnt_q      <= '0;
            color_q    <= '0;
            rd_valid_q <= 1'b0;
            wr_err_q   <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            color_q    <= color_d;
            rd_valid_q <= bus.rd_en;
            wr_err_q   <= wr_err_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_valid_q ? bus.mem_dout : '0;
    assign bus.wr_err   = wr_err_q;
    assign bus.clr_done = clr_done_q;
    assign bus.clr_busy = (state_q != StRun);

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Randomised bench for fb_port_arbiter against a transaction-level framebuffer model.
module tb_fb_port_arbiter;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 12;
    localparam int unsigned DEPTH      = 60000;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    always #20 clk = ~clk;

    fb_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fb_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Block RAM model, one-cycle read latency.
    logic [DATA_W-1:0] bram [0:65535];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) bram[bus.mem_addr] = bus.mem_din;
            else bus.mem_dout <= bram[bus.mem_addr];
        end
    end

    // Reference model: expected memory image, pending writes, clear progress.
    logic [DATA_W-1:0] ref_mem [0:65535];
    wr_t               q[$];
    int                mode;      // 0 normal, 1 draining, 2 clearing
    int                clr_next;
    logic [DATA_W-1:0] clr_col;
    bit                exp_rv, exp_err, exp_done;
    logic [DATA_W-1:0] exp_rd;

    int vectors = 0;
    int miscompares = 0;
    int obs_clr_writes, obs_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.clr_start = 1'b0;
        bus.clr_color = '0;
    endtask

    task automatic model_reset();
        q.delete();
        mode     = 0;
        clr_next = 0;
        exp_rv   = 1'b0;
        exp_rd   = '0;
        exp_err  = 1'b0;
        exp_done = 1'b0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        #1;
        check("rst_busy", bus.clr_busy, 0);
        check("rst_valid", bus.rd_valid, 0);
        check("rst_data", bus.rd_data, 0);
        check("rst_err", bus.wr_err, 0);
        check("rst_done", bus.clr_done, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One clock: check outputs mid-cycle, then advance the model past the edge.
    task automatic step();
        bit                e_en, e_we, e_ready;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_din;
        int                sz0, mode0;
        @(negedge clk);
        sz0     = q.size();
        mode0   = mode;
        e_ready = (mode0 == 0) && (sz0 < FIFO_DEPTH);
        e_en    = 1'b0;
        e_we    = 1'b0;
        e_addr  = '0;
        e_din   = '0;
        if (bus.rd_en) begin
            e_en   = 1'b1;
            e_addr = bus.rd_addr;
        end else if (mode0 == 2) begin
            e_en   = 1'b1;
            e_we   = 1'b1;
            e_addr = ADDR_W'(clr_next);
            e_din  = clr_col;
        end else if (sz0 > 0) begin
            e_en   = 1'b1;
            e_we   = 1'b1;
            e_addr = q[0].a;
            e_din  = q[0].d;
        end
        check("wr_ready", bus.wr_ready, e_ready);
        check("mem_en", bus.mem_en, e_en);
        check("mem_we", bus.mem_we, e_we);
        if (e_en) check("mem_addr", bus.mem_addr, e_addr);
        if (e_we) check("mem_din", bus.mem_din, e_din);
        check("rd_valid", bus.rd_valid, exp_rv);
        check("rd_data", bus.rd_data, exp_rd);
        check("wr_err", bus.wr_err, exp_err);
        check("clr_busy", bus.clr_busy, mode0 != 0);
        check("clr_done", bus.clr_done, exp_done);
        if (bus.clr_busy && bus.mem_we && bus.mem_din == clr_col) obs_clr_writes++;
        if (bus.clr_done) obs_done++;

        exp_rv   = bus.rd_en;
        exp_rd   = bus.rd_en ? ref_mem[bus.rd_addr] : '0;
        exp_err  = 1'b0;
        exp_done = 1'b0;
        if (e_we) ref_mem[e_addr] = e_din;
        if (mode0 == 2) begin
            if (e_we) begin
                if (clr_next == DEPTH - 1) begin
                    clr_next = 0;
                    exp_done = 1'b1;
                    mode     = 0;
                end else begin
                    clr_next++;
                end
            end
        end else if (!bus.rd_en && sz0 > 0) begin
            void'(q.pop_front());
        end
        if (bus.wr_valid && e_ready) begin
            if (bus.wr_addr < DEPTH) q.push_back('{a: bus.wr_addr, d: bus.wr_data});
            else exp_err = 1'b1;
        end
        if (mode0 == 1 && sz0 == 0) begin
            mode     = 2;
            clr_next = 0;
        end
        if (mode0 == 0 && bus.clr_start) begin
            mode    = 1;
            clr_col = bus.clr_color;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic random_inputs(input int rd_pct, input bit allow_wr);
        bus.rd_en    = ($urandom_range(99) < rd_pct);
        bus.rd_addr  = ADDR_W'($urandom_range(65535));
        bus.wr_valid = allow_wr && ($urandom_range(9) < 7);
        bus.wr_addr  = ($urandom_range(7) == 0) ? ADDR_W'($urandom_range(65535, DEPTH))
                                                : ADDR_W'($urandom_range(DEPTH - 1));
        bus.wr_data  = DATA_W'($urandom);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 65536; i++) begin
            bram[i]    = DATA_W'(i * 7);
            ref_mem[i] = DATA_W'(i * 7);
        end
        bram[5]    = 12'hABC;
        ref_mem[5] = 12'hABC;
        obs_clr_writes = 0;
        obs_done       = 0;
        do_reset();

        // Directed read of a preloaded word.
        bus.rd_en = 1'b1;
        bus.rd_addr = 16'd5;
        step();
        bus.rd_en = 1'b0;
        step();
        step();

        // Fill the FIFO behind continuous reads, then let it drain.
        bus.rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.rd_addr  = ADDR_W'(i);
            bus.wr_valid = 1'b1;
            bus.wr_addr  = ADDR_W'(1000 + i);
            bus.wr_data  = DATA_W'(12'h100 + i);
            step();
        end
        drive_idle();
        for (int i = 0; i < 6; i++) step();

        // Range boundary writes.
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 16'd60000;
        bus.wr_data  = 12'h555;
        step();
        bus.wr_addr  = 16'd59999;
        bus.wr_data  = 12'h0F0;
        step();
        drive_idle();
        for (int i = 0; i < 3; i++) step();

        // Full clear with two writes queued ahead of it.
        bus.rd_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = ADDR_W'(200 + i);
            bus.wr_data  = DATA_W'(12'h0A0 + i);
            step();
        end
        drive_idle();
        bus.clr_start = 1'b1;
        bus.clr_color = 12'hF00;
        step();
        bus.clr_start = 1'b0;
        obs_clr_writes = 0;
        obs_done = 0;
        n = 0;
        while (mode != 0 && n < 61000) begin
            bus.wr_valid = $urandom_range(1);
            step();
            n++;
        end
        check("clr_timeout", bus.clr_busy, 0);
        step();
        check("clr_writes", obs_clr_writes, 60000);
        check("clr_done_cnt", obs_done, 1);

        // Random traffic, including reads of the cleared image.
        for (int i = 0; i < 2000; i++) begin
            random_inputs(50, 1'b1);
            step();
        end
        drive_idle();
        for (int i = 0; i < 6; i++) step();

        // Clear under 50% read traffic, reset partway through.
        bus.clr_start = 1'b1;
        bus.clr_color = DATA_W'($urandom);
        step();
        bus.clr_start = 1'b0;
        n = 0;
        while (!(mode == 2 && clr_next == 1000) && n < 5000) begin
            random_inputs(50, 1'b1);
            step();
            n++;
        end
        check("clr1000_reach", clr_next, 1000);
        do_reset();
        for (int i = 0; i < 3; i++) step();

        // Restart must begin again at address 0.
        bus.clr_start = 1'b1;
        bus.clr_color = DATA_W'($urandom);
        step();
        bus.clr_start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            random_inputs(50, 1'b1);
            step();
        end
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
